spi_target: RTL and testbench

SPI_TARGET -- requirements
Module: spi_target

---
 rtl/spi_target.sv | 169 ++++++++++++++++
 tb/tb_spi_target.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/spi_target.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | spi_target : SPI mode-0 target, oversampled from FastClk, byte RX/TX        |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
module spi_target #(
  parameter logic [7:0] FILL_BYTE = 8'hFF
) (
  input  logic       FastClk,
  input  logic       Reset,
  input  logic       SPI_Clk,
  input  logic       SPI_Cs,
  input  logic       SPI_Di,
  output logic       SPI_Do,
  output logic       SPI_DoEn,
  output logic [7:0] RXData,
  output logic       RXValid,
  input  logic       RXAck,
  input  logic [7:0] TXData,
  input  logic       TXWrite,
  output logic       TXEmpty,
  output logic [8:0] ByteCount,
  output logic       Selected,
  output logic       EndStrobe,
  output logic       Overrun,
  input  logic       ClearOverrun
);

  typedef enum logic [1:0] {
    WAIT_IDLE = 2'd0,
    IDLE      = 2'd1,
    ACTIVE    = 2'd2
  } state_t;

  state_t     r_state;
  state_t     w_next_state;

  logic [2:0] r_sck_sync;
  logic [1:0] r_cs_sync;
  logic [1:0] r_di_sync;

  logic [2:0] r_bit_cnt;
  logic [6:0] r_rx_shift;
  logic [7:0] r_rx_data;
  logic       r_rx_valid;
  logic       r_overrun;
  logic [8:0] r_byte_count;
  logic [7:0] r_tx_shift;
  logic [7:0] r_tx_hold;
  logic       r_tx_empty;
  logic       r_end_strobe;

  logic       w_cs;
  logic       w_sck_rise;
  logic       w_sck_fall;
  logic       w_active;
  logic       w_start;
  logic       w_end;
  logic       w_rx_done;
  logic       w_tx_load;
  logic [7:0] w_rx_byte;

  // CS sync resets to 0 so a selection already in progress at reset release
  // is ignored until CS is actually seen high.
  always_ff @(posedge FastClk or posedge Reset) begin
    if (Reset) begin
      r_sck_sync <= 3'b000;
      r_cs_sync  <= 2'b00;
      r_di_sync  <= 2'b00;
    end else begin
      r_sck_sync <= {r_sck_sync[1:0], SPI_Clk};
      r_cs_sync  <= {r_cs_sync[0], SPI_Cs};
      r_di_sync  <= {r_di_sync[0], SPI_Di};
    end
  end

  assign w_cs       = r_cs_sync[1];
  assign w_sck_rise = r_sck_sync[1] & ~r_sck_sync[2];
  assign w_sck_fall = ~r_sck_sync[1] & r_sck_sync[2];
  assign w_active   = (r_state == ACTIVE);
  assign w_rx_byte  = {r_rx_shift, r_di_sync[1]};
  assign w_rx_done  = w_active & w_sck_rise & (r_bit_cnt == 3'd7);
  assign w_tx_load  = w_start | (w_active & w_sck_fall & (r_bit_cnt == 3'd0));

  always_ff @(posedge FastClk or posedge Reset) begin
    if (Reset) r_state <= WAIT_IDLE;
    else       r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    w_start      = 1'b0;
    w_end        = 1'b0;
    case (r_state)
      WAIT_IDLE: if (w_cs) w_next_state = IDLE;
      IDLE: if (!w_cs) begin
        w_next_state = ACTIVE;
        w_start      = 1'b1;
      end
      ACTIVE: if (w_cs) begin
        w_next_state = IDLE;
        w_end        = 1'b1;
      end
      default: w_next_state = WAIT_IDLE;
    endcase
  end

  always_ff @(posedge FastClk or posedge Reset) begin
    if (Reset) begin
      r_bit_cnt    <= 3'd0;
      r_rx_shift   <= 7'd0;
      r_rx_data    <= 8'd0;
      r_rx_valid   <= 1'b0;
      r_overrun    <= 1'b0;
      r_byte_count <= 9'd0;
      r_tx_shift   <= 8'd0;
      r_tx_hold    <= 8'd0;
      r_tx_empty   <= 1'b1;
      r_end_strobe <= 1'b0;
    end else begin
      r_end_strobe <= w_end;

      if (w_start) begin
        r_bit_cnt    <= 3'd0;
        r_rx_shift   <= 7'd0;
        r_byte_count <= 9'd0;
      end else if (w_active && w_sck_rise) begin
        r_rx_shift <= w_rx_byte[6:0];
        r_bit_cnt  <= r_bit_cnt + 3'd1;
        if (r_bit_cnt == 3'd7) begin
          r_rx_data    <= w_rx_byte;
          r_byte_count <= r_byte_count + 9'd1;
        end
      end

      // A completing byte wins over a same-cycle acknowledge.
      if (w_rx_done)   r_rx_valid <= 1'b1;
      else if (RXAck)  r_rx_valid <= 1'b0;

      if (ClearOverrun)                             r_overrun <= 1'b0;
      else if (w_rx_done && r_rx_valid && !RXAck)   r_overrun <= 1'b1;

      if (w_tx_load)
        r_tx_shift <= r_tx_empty ? FILL_BYTE : r_tx_hold;
      else if (w_active && w_sck_fall)
        r_tx_shift <= {r_tx_shift[6:0], 1'b0};

      // A write coinciding with a load is held for the next byte, not bypassed.
      if (TXWrite) begin
        r_tx_hold  <= TXData;
        r_tx_empty <= 1'b0;
      end else if (w_tx_load) begin
        r_tx_empty <= 1'b1;
      end
    end
  end

  assign SPI_Do    = w_active ? r_tx_shift[7] : 1'b1;
  assign SPI_DoEn  = w_active;
  assign Selected  = w_active;
  assign RXData    = r_rx_data;
  assign RXValid   = r_rx_valid;
  assign TXEmpty   = r_tx_empty;
  assign ByteCount = r_byte_count;
  assign EndStrobe = r_end_strobe;
  assign Overrun   = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_spi_target.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_spi_target : directed self-checking bench for spi_target                 |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
module tb_spi_target;

  logic       FastClk = 1'b0;
  logic       Reset;
  logic       SPI_Clk, SPI_Cs, SPI_Di;
  logic       SPI_Do, SPI_DoEn;
  logic [7:0] RXData;
  logic       RXValid, RXAck;
  logic [7:0] TXData;
  logic       TXWrite, TXEmpty;
  logic [8:0] ByteCount;
  logic       Selected, EndStrobe, Overrun, ClearOverrun;

  int n_tests = 0;
  int n_fail  = 0;
  int end_cnt = 0;

  spi_target #(.FILL_BYTE(8'hFF)) dut (
    .FastClk(FastClk), .Reset(Reset),
    .SPI_Clk(SPI_Clk), .SPI_Cs(SPI_Cs), .SPI_Di(SPI_Di),
    .SPI_Do(SPI_Do), .SPI_DoEn(SPI_DoEn),
    .RXData(RXData), .RXValid(RXValid), .RXAck(RXAck),
    .TXData(TXData), .TXWrite(TXWrite), .TXEmpty(TXEmpty),
    .ByteCount(ByteCount), .Selected(Selected), .EndStrobe(EndStrobe),
    .Overrun(Overrun), .ClearOverrun(ClearOverrun)
  );

  always #5 FastClk = ~FastClk;

  always @(negedge FastClk) if (EndStrobe) end_cnt++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge FastClk);
  endtask

  task automatic cs_low();
    SPI_Cs = 1'b0;
    tick(4);
  endtask

  task automatic cs_high();
    SPI_Clk = 1'b0;
    tick(4);
    SPI_Cs = 1'b1;
    tick(6);
  endtask

  task automatic pulse_ack();
    RXAck = 1'b1; tick(1); RXAck = 1'b0; tick(1);
  endtask

  task automatic pulse_clr();
    ClearOverrun = 1'b1; tick(1); ClearOverrun = 1'b0; tick(1);
  endtask

  // SCK period is 8 FastClk cycles; MISO is sampled as SCK rises.
  task automatic xfer(input logic [7:0] mosi, input int nbits, input logic [7:0] wr_data,
                      input bit wr_bound, input bit ack_last, output logic [7:0] miso);
    miso = 8'h00;
    for (int i = 7; i >= 8 - nbits; i--) begin
      SPI_Clk = 1'b0;
      SPI_Di  = mosi[i];
      if (wr_bound && i == 7) begin
        tick(2); TXData = wr_data; TXWrite = 1'b1; tick(1); TXWrite = 1'b0; tick(1);
      end else begin
        tick(4);
      end
      SPI_Clk = 1'b1;
      miso[i] = SPI_Do;
      if (ack_last && i == 0) begin
        tick(2); RXAck = 1'b1; tick(1); RXAck = 1'b0; tick(1);
      end else begin
        tick(4);
      end
    end
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] miso;
    int e0, errs;

    Reset = 1'b1; SPI_Clk = 1'b0; SPI_Cs = 1'b1; SPI_Di = 1'b0;
    RXAck = 1'b0; TXData = 8'h00; TXWrite = 1'b0; ClearOverrun = 1'b0;
    tick(3);
    check("rst_do",    SPI_Do, 1);
    check("rst_doen",  SPI_DoEn, 0);
    check("rst_rxv",   RXValid, 0);
    check("rst_txe",   TXEmpty, 1);
    check("rst_bc",    ByteCount, 0);
    check("rst_ovr",   Overrun, 0);
    Reset = 1'b0;
    tick(5);
    check("idle_do",   SPI_Do, 1);
    check("idle_sel",  Selected, 0);

    // Single byte with preloaded TX data
    TXData = 8'hA5; TXWrite = 1'b1; tick(1); TXWrite = 1'b0; tick(1);
    check("txw_empty", TXEmpty, 0);
    cs_low();
    check("act_sel",   Selected, 1);
    check("act_doen",  SPI_DoEn, 1);
    check("act_txe",   TXEmpty, 1);
    xfer(8'h3C, 8, 8'h00, 0, 0, miso);
    check("b1_miso",   miso, 8'hA5);
    check("b1_rxd",    RXData, 8'h3C);
    check("b1_rxv",    RXValid, 1);
    check("b1_bc",     ByteCount, 1);
    cs_high();
    check("b1_txe",    TXEmpty, 1);
    check("b1_deen",   SPI_DoEn, 0);
    pulse_ack();
    check("ack_rxv",   RXValid, 0);

    // Three bytes of fill, one end strobe
    e0 = end_cnt;
    cs_low();
    xfer(8'h01, 8, 8'h00, 0, 0, miso); check("f1_miso", miso, 8'hFF);
    xfer(8'h02, 8, 8'h00, 0, 0, miso); check("f2_miso", miso, 8'hFF);
    xfer(8'h03, 8, 8'h00, 0, 0, miso); check("f3_miso", miso, 8'hFF);
    cs_high();
    check("f_bc",      ByteCount, 3);
    check("f_rxd",     RXData, 8'h03);
    check("f_end",     end_cnt - e0, 1);
    check("f_ovr",     Overrun, 1);
    pulse_clr();
    pulse_ack();
    check("f_clr",     Overrun, 0);

    // Overrun, then an ack coinciding with completion
    cs_low();
    xfer(8'h11, 8, 8'h00, 0, 0, miso);
    xfer(8'h22, 8, 8'h00, 0, 0, miso);
    check("o_rxd",     RXData, 8'h22);
    check("o_ovr",     Overrun, 1);
    pulse_clr();
    check("o_clr",     Overrun, 0);
    xfer(8'h33, 8, 8'h00, 0, 1, miso);
    check("ackc_rxd",  RXData, 8'h33);
    check("ackc_rxv",  RXValid, 1);
    check("ackc_ovr",  Overrun, 0);
    cs_high();
    pulse_ack();

    // Partial byte aborted by deselect
    e0 = end_cnt;
    cs_low();
    xfer(8'hA7, 8, 8'h00, 0, 0, miso);
    pulse_ack();
    xfer(8'hFF, 5, 8'h00, 0, 0, miso);
    cs_high();
    check("p_rxv",     RXValid, 0);
    check("p_bc",      ByteCount, 1);
    check("p_end",     end_cnt - e0, 1);
    cs_low();
    xfer(8'h96, 8, 8'h00, 0, 0, miso);
    cs_high();
    check("p_next",    RXData, 8'h96);
    check("p_nbc",     ByteCount, 1);
    pulse_ack();

    // Reset mid-byte with CS held low
    cs_low();
    xfer(8'h55, 3, 8'h00, 0, 0, miso);
    Reset = 1'b1;
    #1;
    check("ar_doen",   SPI_DoEn, 0);
    check("ar_do",     SPI_Do, 1);
    tick(2);
    check("ar_rxd",    RXData, 8'h00);
    check("ar_bc",     ByteCount, 0);
    Reset = 1'b0;
    tick(4);
    xfer(8'hEE, 8, 8'h00, 0, 0, miso);
    check("ar_ign_en", SPI_DoEn, 0);
    check("ar_ign_rv", RXValid, 0);
    check("ar_ign_bc", ByteCount, 0);
    cs_high();
    cs_low();
    check("ar_sel",    SPI_DoEn, 1);
    xfer(8'hC3, 8, 8'h00, 0, 0, miso);
    cs_high();
    check("ar_rxd2",   RXData, 8'hC3);
    check("ar_bc2",    ByteCount, 1);
    pulse_ack();

    // 512 bytes: count wrap, TX write coincident with a boundary load
    check("w_txe0",    TXEmpty, 1);
    errs = 0;
    cs_low();
    for (int b = 0; b < 512; b++) begin
      xfer(b[7:0], 8, 8'h5A, (b == 300), 0, miso);
      if (b == 300) begin
        check("w_bnd_miso", miso, 8'hFF);
        check("w_bnd_txe",  TXEmpty, 0);
      end else if (b == 301) begin
        check("w_nxt_miso", miso, 8'h5A);
        check("w_nxt_txe",  TXEmpty, 1);
      end else if (miso != 8'hFF) begin
        errs++;
      end
      if (b == 510) check("w_bc511", ByteCount, 511);
    end
    check("w_fill",    errs, 0);
    check("w_bc0",     ByteCount, 0);
    check("w_rxd",     RXData, 8'hFF);
    cs_high();
    pulse_clr();
    pulse_ack();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
